mpsoc_ahb3_req_master: RTL and testbench
========================================

# mpsoc_ahb3_req_master

AHB3-Lite bus master that turns a simple valid/ready request stream into pipelined AHB3-Lite single transfers. It sits directly upstream of `mpsoc_ahb3_spram`, or of any AHB3-Lite slave/interconnect port. It overlaps the address phase of transfer N+1 with the data phase of transfer N, honours `HREADY` wait states, and implements the two-cycle `ERROR` response. Each completed transfer returns one response beat.

## Interface
Parameters:
- `XLEN`, 64, data bus width in bits.
- `PLEN`, 64, address width in bits.

Ports:
- `HCLK` in 1: the single clock.
- `HRESET` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at the `HCLK` rising edge.
- `req_addr` in PLEN: byte address; must be aligned to `req_size` (caller guarantees).
- `req_we` in 1: 1 = write, 0 = read.
- `req_size` in 3: `HSIZE` encoding, ≤ log2(XLEN/8) (caller guarantees).
- `req_wdata` in XLEN: write data.
- `rsp_valid` out 1: one-cycle pulse per completed transfer. No backpressure; the consumer always accepts.
- `rsp_rdata` out XLEN: read data; undefined for writes.
- `rsp_err` out 1: transfer ended with `HRESP=ERROR`.
- `HSEL` out 1; `HADDR` out PLEN; `HWDATA` out XLEN; `HRDATA` in XLEN; `HWRITE` out 1; `HSIZE` out 3; `HBURST` out 3; `HPROT` out 4; `HTRANS` out 2; `HMASTLOCK` out 1: standard AHB3-Lite master signals.
- `HREADY` in 1: bus ready (slave `HREADYOUT` after the mux).
- `HRESP` in 1: 0 = OKAY, 1 = ERROR.

## Operation

**Address register A** (`a_valid`, `a_addr`, `a_we`, `a_size`, `a_wdata`)
- Drives `HADDR` / `HWRITE` / `HSIZE` directly from its fields.
- `HTRANS` is NONSEQ when `a_valid && !err_hold`, otherwise IDLE.
- `HSEL = HTRANS[1]`.

**Data register D** (`d_valid`, `d_we`, `d_wdata`)
- Drives `HWDATA = d_wdata`.

**Acceptance and completion**
- `a_accept = a_valid && !err_hold && HREADY`.
- `req_ready = !a_valid || a_accept`. This is combinational from `HREADY`, by design.
- On `a_accept`, A moves to D. A is reloaded from `req_*` if a request is accepted the same cycle, otherwise `a_valid` clears.
- `d_done = d_valid && HREADY`.
  - On `d_done`, the registered response loads: `rsp_valid <= 1`, `rsp_rdata <= HRDATA`, `rsp_err <= HRESP`.
  - D clears unless refilled by `a_accept` in the same cycle.

**Error handling**
- When `d_valid && HRESP && !HREADY` (first error cycle), set `err_hold`.
- With `err_hold` set, `HTRANS` is IDLE in the second error cycle, so the pending A transfer is not presented.
- `err_hold` clears on `HREADY=1`. A is then re-presented as NONSEQ the following cycle. The transfer is retried, not dropped.

**Constant outputs**
- `HBURST` = SINGLE (3'b000).
- `HPROT` = 4'b0011 (data, privileged, non-bufferable, non-cacheable).
- `HMASTLOCK` = 0.

**Reset** (synchronous, `HRESET=1` at an `HCLK` edge)
- Clears `a_valid`, `d_valid`, `err_hold`, `rsp_valid`, `rsp_err`.
- Sets `HADDR=0`, `HWDATA=0`, `HWRITE=0`, `HSIZE=0`, `rsp_rdata=0`.
- Resulting outputs: `HTRANS` = IDLE, `HSEL` = 0, `req_ready` = 1.
- Reset mid-transfer abandons A and D with no response. A slave still in a data phase sees `HTRANS=IDLE` next.

## Timing
- Request accepted at edge N → `HTRANS=NONSEQ` during cycle N+1.
- With a zero-wait slave: data phase in N+2, `rsp_valid` high in N+3. Read latency is 3 cycles from acceptance.
- Back-to-back requests achieve one transfer per cycle. `req_ready` stays high while `HREADY=1`.
- `HREADY=0` holds all address-phase outputs and `HWDATA` stable and forces `req_ready=0` while A is occupied.
- Responses are returned strictly in issue order. At most 2 transfers are in flight (A + D).
- Error sequence:
  - cycle E1: `HRESP=1`, `HREADY=0`, `HTRANS` may be NONSEQ.
  - cycle E2: `HRESP=1`, `HREADY=1`, `HTRANS=IDLE`.
  - cycle E2+1: `rsp_err=1` pulse, and A is re-presented.

## Structure
- Shared package `mpsoc_ahb3_pkg` holds these constants:
  - `HTRANS_IDLE`=2'b00, `HTRANS_BUSY`=2'b01, `HTRANS_NONSEQ`=2'b10, `HTRANS_SEQ`=2'b11.
  - `HBURST_SINGLE`=3'b000.
  - `HPROT_DATA_PRIV`=4'b0011.
  - `HRESP_OKAY`=1'b0, `HRESP_ERROR`=1'b1.
  - `HSIZE_B8`..`HSIZE_B64`=3'd0..3'd3.
- Single module. No sub-module is needed; the A and D registers, `err_hold` and the response register are inline.

## Test plan
- **Write then read** (slave: `mpsoc_ahb3_spram`): write 0x10 with data 0xDEADBEEF_CAFEF00D, size 3, then read 0x10 → second response has `rsp_rdata`=0xDEADBEEF_CAFEF00D, `rsp_err`=0, and `rsp_valid` 3 cycles after read acceptance.
- **Back-to-back writes**: 4 writes to 0x00/0x08/0x10/0x18 with `req_valid` held → `HTRANS`=NONSEQ for 4 consecutive cycles, 4 consecutive `rsp_valid` pulses; read-back returns the written values.
- **Wait states**: slave model holds `HREADY`=0 for 2 cycles in transfer 2's data phase → transfer 3's `HADDR`/`HWRITE` stay stable, `req_ready`=0 for those 2 cycles, responses arrive in order 1, 2, 3.
- **Error with retry**: slave gives a two-cycle ERROR on transfer 1 while transfer 2 is pending → `HTRANS`=IDLE in E2, `rsp_err`=1 for transfer 1, transfer 2 re-issued as NONSEQ and completes with `rsp_err`=0.
- **Reset mid-operation**: assert `HRESET` for 1 cycle while a transfer is in its data phase → next cycle `HTRANS`=IDLE, `rsp_valid`=0, `req_ready`=1. A new request afterwards completes normally.

Source files
------------

// File: rtl/mpsoc_ahb3_pkg.sv
// AHB3-Lite encodings shared by the MPSoC AHB3 masters and slaves.
// Transfer types, burst, protection, response and size codes.
package mpsoc_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_B8  = 3'd0;
    localparam logic [2:0] HSIZE_B16 = 3'd1;
    localparam logic [2:0] HSIZE_B32 = 3'd2;
    localparam logic [2:0] HSIZE_B64 = 3'd3;

endpackage

// File: rtl/mpsoc_ahb3_req_master.sv
// AHB3-Lite master: valid/ready request stream to pipelined single transfers.
// Address register A overlaps the data phase held in register D.
module mpsoc_ahb3_req_master
    import mpsoc_ahb3_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PLEN = 64
) (
    input  logic            HCLK,
    input  logic            HRESET,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [PLEN-1:0] req_addr,
    input  logic            req_we,
    input  logic [2:0]      req_size,
    input  logic [XLEN-1:0] req_wdata,

    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,

    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic            HREADY,
    input  logic            HRESP
);

    logic            a_valid;
    logic [PLEN-1:0] a_addr;
    logic            a_we;
    logic [2:0]      a_size;
    logic [XLEN-1:0] a_wdata;

    logic            d_valid;
    logic [XLEN-1:0] d_wdata;

    logic            err_hold;

    logic            a_accept;
    logic            d_done;
    logic            req_fire;
    logic            err_first;

    assign a_accept  = a_valid && !err_hold && HREADY;
    assign d_done    = d_valid && HREADY;
    assign req_ready = !a_valid || a_accept;
    assign req_fire  = req_valid && req_ready;
    assign err_first = d_valid && (HRESP == HRESP_ERROR) && !HREADY;

    assign HTRANS    = (a_valid && !err_hold) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HSEL      = HTRANS[1];
    assign HADDR     = a_addr;
    assign HWRITE    = a_we;
    assign HSIZE     = a_size;
    assign HWDATA    = d_wdata;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA_PRIV;
    assign HMASTLOCK = 1'b0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_valid <= 1'b0;
            a_addr  <= '0;
            a_we    <= 1'b0;
            a_size  <= '0;
            a_wdata <= '0;
        end else if (req_fire) begin
            a_valid <= 1'b1;
            a_addr  <= req_addr;
            a_we    <= req_we;
            a_size  <= req_size;
            a_wdata <= req_wdata;
        end else if (a_accept) begin
            a_valid <= 1'b0;
        end
    end

    // D is refilled from A in the same edge it retires, keeping one beat per cycle
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            d_valid <= 1'b0;
            d_wdata <= '0;
        end else if (a_accept) begin
            d_valid <= 1'b1;
            d_wdata <= a_wdata;
        end else if (d_done) begin
            d_valid <= 1'b0;
        end
    end

    // Masks A during the second ERROR cycle so it is retried afterwards
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_hold <= 1'b0;
        end else if (err_first) begin
            err_hold <= 1'b1;
        end else if (HREADY) begin
            err_hold <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= d_done;
            if (d_done) begin
                rsp_rdata <= HRDATA;
                rsp_err   <= HRESP;
            end
        end
    end

endmodule

// File: tb/tb_mpsoc_ahb3_req_master.sv
// Directed bench for mpsoc_ahb3_req_master against a small AHB3-Lite memory
// slave with programmable wait states and two-cycle ERROR responses.
module tb_mpsoc_ahb3_req_master;
    import mpsoc_ahb3_pkg::*;

    localparam int XLEN = 64;
    localparam int PLEN = 64;

    localparam logic [63:0] DW = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] D0 = 64'h0101_0101_A0A0_0000;
    localparam logic [63:0] D1 = 64'h2323_2323_B1B1_1111;
    localparam logic [63:0] D2 = 64'h4545_4545_C2C2_2222;
    localparam logic [63:0] D3 = 64'h6767_6767_D3D3_3333;

    logic            HCLK = 1'b0;
    logic            HRESET = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [PLEN-1:0] req_addr = '0;
    logic            req_we = 1'b0;
    logic [2:0]      req_size = '0;
    logic [XLEN-1:0] req_wdata = '0;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;
    logic            HSEL;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic [XLEN-1:0] HRDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic            HREADY;
    logic            HRESP;

    mpsoc_ahb3_req_master #(.XLEN(XLEN), .PLEN(PLEN)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // Slave model: one data phase tracked, memory of 8 doublewords
    bit [63:0]   mem [8];
    logic        sp_valid = 1'b0;
    logic [63:0] sp_addr = '0;
    logic        sp_we = 1'b0;
    int          sp_idx = 0;
    int          ph = 0;
    int          xfer_cnt = 0;
    int          err_on = -1;
    int          wait_on = -1;
    int          wait_len = 0;

    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        if (sp_valid) begin
            if (sp_idx == err_on) begin
                HRESP  = HRESP_ERROR;
                HREADY = (ph != 0);
            end else if (sp_idx == wait_on && ph < wait_len) begin
                HREADY = 1'b0;
            end
        end
    end

    assign HRDATA = sp_valid ? mem[sp_addr[5:3]] : '0;

    always @(posedge HCLK) begin
        if (HRESET) begin
            sp_valid <= 1'b0;
            ph       <= 0;
        end else if (HREADY) begin
            if (sp_valid && sp_we && sp_idx != err_on)
                mem[sp_addr[5:3]] <= HWDATA;
            sp_valid <= HTRANS[1];
            sp_addr  <= HADDR;
            sp_we    <= HWRITE;
            sp_idx   <= xfer_cnt;
            if (HTRANS[1])
                xfer_cnt <= xfer_cnt + 1;
            ph <= 0;
        end else begin
            ph <= ph + 1;
        end
    end

    // Per-cycle history and response log, sampled mid-cycle
    logic [1:0]  h_trans [1024];
    logic [63:0] h_addr  [1024];
    logic [63:0] h_wdata [1024];
    logic        h_write [1024];
    logic        h_rdy   [1024];
    logic [63:0] rsp_data [$];
    logic        rsp_errq [$];
    int          rsp_cyc  [$];

    always @(negedge HCLK) begin
        h_trans[cyc % 1024] <= HTRANS;
        h_addr[cyc % 1024]  <= HADDR;
        h_wdata[cyc % 1024] <= HWDATA;
        h_write[cyc % 1024] <= HWRITE;
        h_rdy[cyc % 1024]   <= req_ready;
        if (rsp_valid) begin
            rsp_data.push_back(rsp_rdata);
            rsp_errq.push_back(rsp_err);
            rsp_cyc.push_back(cyc);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        @(negedge HCLK);
        #1;
        rsp_data.delete();
        rsp_errq.delete();
        rsp_cyc.delete();
    endtask

    task automatic issue(input logic [63:0] addr, input logic we,
                         input logic [63:0] wd, output int acc);
        bit ok = 1'b0;
        acc = 0;
        @(negedge HCLK);
        req_valid = 1'b1;
        req_addr  = addr;
        req_we    = we;
        req_size  = HSIZE_B64;
        req_wdata = wd;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (i > 0) @(negedge HCLK);
            #4;
            ok  = req_ready;
            acc = cyc;
            @(posedge HCLK);
        end
        if (!ok) chk("req_timeout", 64'd0, 64'd1);
    endtask

    task automatic drop_req();
        @(negedge HCLK);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    int a, b;
    int acc [4];

    initial begin
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        #1;
        chk("rst_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
        chk("rst_hsel", 64'(HSEL), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_rspv", 64'(rsp_valid), 64'd0);
        chk("rst_rsperr", 64'(rsp_err), 64'd0);
        chk("rst_haddr", HADDR, 64'd0);
        chk("rst_hwdata", HWDATA, 64'd0);
        chk("rst_hburst", 64'(HBURST), 64'd0);
        chk("rst_hprot", 64'(HPROT), 64'd3);
        chk("rst_hlock", 64'(HMASTLOCK), 64'd0);

        // Write then read the same doubleword
        clr();
        issue(64'h10, 1'b1, DW, a);
        issue(64'h10, 1'b0, 64'd0, b);
        drop_req();
        idle(6);
        chk("wr_nrsp", 64'(rsp_data.size()), 64'd2);
        chk("wr_trans", 64'(h_trans[(a + 1) % 1024]), 64'(HTRANS_NONSEQ));
        chk("wr_hwrite", 64'(h_write[(a + 1) % 1024]), 64'd1);
        chk("wr_hwdata", h_wdata[(a + 2) % 1024], DW);
        chk("rd_haddr", h_addr[(b + 1) % 1024], 64'h10);
        chk("wr_lat", 64'(rsp_cyc[0] - a), 64'd3);
        chk("rd_lat", 64'(rsp_cyc[1] - b), 64'd3);
        chk("rd_data", rsp_data[1], DW);
        chk("rd_err", 64'(rsp_errq[1]), 64'd0);

        // Back-to-back writes, then read back
        clr();
        issue(64'h00, 1'b1, D0, acc[0]);
        issue(64'h08, 1'b1, D1, acc[1]);
        issue(64'h10, 1'b1, D2, acc[2]);
        issue(64'h18, 1'b1, D3, acc[3]);
        drop_req();
        idle(6);
        chk("b2b_nrsp", 64'(rsp_data.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_acc%0d", i), 64'(acc[i] - acc[0]), 64'(i));
            chk($sformatf("b2b_trans%0d", i),
                64'(h_trans[(acc[0] + 1 + i) % 1024]), 64'(HTRANS_NONSEQ));
            chk($sformatf("b2b_rsp%0d", i),
                64'(rsp_cyc[i] - acc[0]), 64'(3 + i));
        end
        clr();
        issue(64'h00, 1'b0, 64'd0, a);
        issue(64'h08, 1'b0, 64'd0, b);
        issue(64'h10, 1'b0, 64'd0, b);
        issue(64'h18, 1'b0, 64'd0, b);
        drop_req();
        idle(6);
        chk("rb_nrsp", 64'(rsp_data.size()), 64'd4);
        chk("rb_d0", rsp_data[0], D0);
        chk("rb_d1", rsp_data[1], D1);
        chk("rb_d2", rsp_data[2], D2);
        chk("rb_d3", rsp_data[3], D3);

        // Two wait states in transfer 2's data phase
        clr();
        wait_on  = xfer_cnt + 1;
        wait_len = 2;
        issue(64'h00, 1'b0, 64'd0, a);
        issue(64'h08, 1'b0, 64'd0, b);
        issue(64'h10, 1'b0, 64'd0, b);
        drop_req();
        idle(8);
        wait_on = -1;
        chk("ws_nrsp", 64'(rsp_data.size()), 64'd3);
        chk("ws_rdy3", 64'(h_rdy[(a + 3) % 1024]), 64'd0);
        chk("ws_rdy4", 64'(h_rdy[(a + 4) % 1024]), 64'd0);
        chk("ws_rdy5", 64'(h_rdy[(a + 5) % 1024]), 64'd1);
        chk("ws_addr3", h_addr[(a + 3) % 1024], 64'h10);
        chk("ws_addr4", h_addr[(a + 4) % 1024], 64'h10);
        chk("ws_addr5", h_addr[(a + 5) % 1024], 64'h10);
        chk("ws_wr4", 64'(h_write[(a + 4) % 1024]), 64'd0);
        chk("ws_trans4", 64'(h_trans[(a + 4) % 1024]), 64'(HTRANS_NONSEQ));
        chk("ws_r0", rsp_data[0], D0);
        chk("ws_r1", rsp_data[1], D1);
        chk("ws_r2", rsp_data[2], D2);
        chk("ws_c0", 64'(rsp_cyc[0] - a), 64'd3);
        chk("ws_c1", 64'(rsp_cyc[1] - a), 64'd6);
        chk("ws_c2", 64'(rsp_cyc[2] - a), 64'd7);

        // ERROR on transfer 1 with transfer 2 pending in A
        clr();
        err_on = xfer_cnt;
        issue(64'h00, 1'b0, 64'd0, a);
        issue(64'h08, 1'b0, 64'd0, b);
        drop_req();
        idle(7);
        err_on = -1;
        chk("er_nrsp", 64'(rsp_data.size()), 64'd2);
        chk("er_e2_idle", 64'(h_trans[(a + 3) % 1024]), 64'(HTRANS_IDLE));
        chk("er_e2_hsel", 64'(h_trans[(a + 3) % 1024] >> 1), 64'd0);
        chk("er_retry", 64'(h_trans[(a + 4) % 1024]), 64'(HTRANS_NONSEQ));
        chk("er_raddr", h_addr[(a + 4) % 1024], 64'h08);
        chk("er_err0", 64'(rsp_errq[0]), 64'd1);
        chk("er_c0", 64'(rsp_cyc[0] - a), 64'd4);
        chk("er_err1", 64'(rsp_errq[1]), 64'd0);
        chk("er_d1", rsp_data[1], D1);
        chk("er_c1", 64'(rsp_cyc[1] - a), 64'd6);

        // Reset during a data phase
        clr();
        issue(64'h18, 1'b0, 64'd0, a);
        drop_req();
        @(negedge HCLK);
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        #1;
        chk("mr_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
        chk("mr_rspv", 64'(rsp_valid), 64'd0);
        chk("mr_ready", 64'(req_ready), 64'd1);
        idle(4);
        chk("mr_nrsp", 64'(rsp_data.size()), 64'd0);
        clr();
        issue(64'h08, 1'b0, 64'd0, a);
        drop_req();
        idle(5);
        chk("mr_new_n", 64'(rsp_data.size()), 64'd1);
        chk("mr_new_d", rsp_data[0], D1);
        chk("mr_new_e", 64'(rsp_errq[0]), 64'd0);
        chk("mr_new_c", 64'(rsp_cyc[0] - a), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
